// File: rtl/busca_decodifica.sv
// busca_decodifica: instruction fetch/decode stage that sits in front of the control unit.
// It holds the program counter and reads one 8-bit byte per instruction from a program
// ROM with one cycle of read latency. Each byte is split into opcode and operand.
// JMP and HALT are handled inside this stage. Every other opcode is sent to the control
// unit using the instrValida/execPronto handshake.
// Optional feature: define BUSCA_JZ_EN to handle JZ (jump if regA==0) inside this stage.
module busca_decodifica #(
   parameter int         ADDR_W   = 4,
   parameter logic [3:0] JMP_OPC  = 4'b1110,
   parameter logic [3:0] HALT_OPC = 4'b1111,
   parameter logic [3:0] JZ_OPC   = 4'b1011
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              enable,
   output logic [ADDR_W-1:0] endProg,
   output logic              rdProg,
   input  logic [7:0]        dataProg,
   output logic [3:0]        opcode,
   output logic [3:0]        operando,
   output logic              instrValida,
   input  logic              execPronto,
   input  logic [7:0]        regA,
   output logic [ADDR_W-1:0] pc,
   output logic              parado
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_WAIT,
      S_DECODE,
      S_EXEC,
      S_HALT
   } state_t;

   state_t            state, state_next;
   logic [7:0]        ir;
   logic [ADDR_W-1:0] pc_next;
   logic [ADDR_W-1:0] jump_target;
   logic [ADDR_W-1:0] pc_inc;

   // The operand is zero-extended or truncated to the PC width.
   assign jump_target = ADDR_W'(ir[3:0]);
   // The increment wraps modulo 2^ADDR_W and no flag is raised.
   assign pc_inc      = pc + ADDR_W'(1);

`ifndef BUSCA_JZ_EN
   // regA and JZ_OPC are used only by the optional JZ path.
   logic unused_cfg;
   assign unused_cfg = ^{regA, (ir[7:4] == JZ_OPC)};
`endif

   // State, PC and instruction register. Reset is asynchronous and takes effect at once.
   always_ff @(posedge clock or posedge reset) begin
      // NOTE: sequential state uses non-blocking assignments. Every register then samples its pre-edge value.
      if (reset) begin
         state <= S_IDLE;
         pc    <= '0;
         ir    <= '0;
      end else begin
         state <= state_next;
         pc    <= pc_next;
         if (state == S_WAIT) ir <= dataProg;
      end
   end

   // Next-state and next-PC decision.
   always_comb begin
      // NOTE: defaults are assigned first. Any path that does not assign a value then holds it, and no latch is inferred.
      state_next = state;
      pc_next    = pc;
      case (state)
         S_IDLE:   if (enable) state_next = S_FETCH;
         S_FETCH:  state_next = S_WAIT;
         S_WAIT:   state_next = S_DECODE;
         S_DECODE: begin
            if (ir[7:4] == HALT_OPC) begin
               state_next = S_HALT;
            end else if (ir[7:4] == JMP_OPC) begin
               pc_next    = jump_target;
               state_next = S_FETCH;
`ifdef BUSCA_JZ_EN
            end else if (ir[7:4] == JZ_OPC) begin
               pc_next    = (regA == 8'h00) ? jump_target : pc_inc;
               state_next = S_FETCH;
`endif
            end else begin
               state_next = S_EXEC;
            end
         end
         S_EXEC: begin
            if (execPronto) begin
               pc_next    = pc_inc;
               state_next = enable ? S_FETCH : S_IDLE;
            end
         end
         S_HALT:   state_next = S_HALT;
         default:  state_next = S_IDLE;
      endcase
   end

   // The outputs decode the state directly. Because of this, reset clears them in the same cycle.
   assign rdProg      = (state == S_FETCH);
   assign endProg     = pc;
   assign instrValida = (state == S_EXEC);
   assign parado      = (state == S_HALT);
   assign opcode      = ir[7:4];
   assign operando    = ir[3:0];

endmodule
